// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter in front of a register file, one single-entry buffer per requester.
// Define REGARB_ROUND_ROBIN_EN for round-robin arbitration on contention; default is fixed priority to A.
module regfile_write_arbiter (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        ReqValidA,
    input  logic        ReqValidB,
    input  logic [4:0]  ReqRegA,
    input  logic [4:0]  ReqRegB,
    input  logic [31:0] ReqDataA,
    input  logic [31:0] ReqDataB,
    output logic        ReqReadyA,
    output logic        ReqReadyB,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        RegWrite,
    output logic        Busy
);

    logic        full_a_q, full_a_d;
    logic [4:0]  reg_a_q, reg_a_d;
    logic [31:0] data_a_q, data_a_d;
    logic        full_b_q, full_b_d;
    logic [4:0]  reg_b_q, reg_b_d;
    logic [31:0] data_b_q, data_b_d;

    logic        reg_write_q, reg_write_d;
    logic [4:0]  wr_reg_q, wr_reg_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic        grant_a, grant_b;
    logic        accept_a, accept_b;

`ifdef REGARB_ROUND_ROBIN_EN
    // High when B won the last contended grant is NOT the case, i.e. B is owed the next one.
    logic        favour_b_q, favour_b_d;

    always_comb begin
        grant_a    = full_a_q & ~(full_b_q & favour_b_q);
        grant_b    = full_b_q & ~grant_a;
        favour_b_d = favour_b_q;
        if (full_a_q && full_b_q) begin
            favour_b_d = grant_a;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            favour_b_q <= 1'b0;
        end else begin
            favour_b_q <= favour_b_d;
        end
    end
`else
    always_comb begin
        grant_a = full_a_q;
        grant_b = full_b_q & ~full_a_q;
    end
`endif

    // A buffer that drains on this edge may be refilled on the same edge.
    assign ReqReadyA = Reset_n & (~full_a_q | grant_a);
    assign ReqReadyB = Reset_n & (~full_b_q | grant_b);
    assign accept_a  = ReqValidA & ReqReadyA;
    assign accept_b  = ReqValidB & ReqReadyB;

    always_comb begin
        full_a_d = full_a_q;
        reg_a_d  = reg_a_q;
        data_a_d = data_a_q;
        full_b_d = full_b_q;
        reg_b_d  = reg_b_q;
        data_b_d = data_b_q;

        if (grant_a) full_a_d = 1'b0;
        if (grant_b) full_b_d = 1'b0;

        // Writes to register 0 are accepted and silently discarded.
        if (accept_a && (ReqRegA != 5'd0)) begin
            full_a_d = 1'b1;
            reg_a_d  = ReqRegA;
            data_a_d = ReqDataA;
        end
        if (accept_b && (ReqRegB != 5'd0)) begin
            full_b_d = 1'b1;
            reg_b_d  = ReqRegB;
            data_b_d = ReqDataB;
        end
    end

    always_comb begin
        reg_write_d = grant_a | grant_b;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        if (grant_a) begin
            wr_reg_d  = reg_a_q;
            wr_data_d = data_a_q;
        end else if (grant_b) begin
            wr_reg_d  = reg_b_q;
            wr_data_d = data_b_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            full_a_q    <= 1'b0;
            reg_a_q     <= 5'd0;
            data_a_q    <= 32'd0;
            full_b_q    <= 1'b0;
            reg_b_q     <= 5'd0;
            data_b_q    <= 32'd0;
            reg_write_q <= 1'b0;
            wr_reg_q    <= 5'd0;
            wr_data_q   <= 32'd0;
        end else begin
            full_a_q    <= full_a_d;
            reg_a_q     <= reg_a_d;
            data_a_q    <= data_a_d;
            full_b_q    <= full_b_d;
            reg_b_q     <= reg_b_d;
            data_b_q    <= data_b_d;
            reg_write_q <= reg_write_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign RegWrite      = reg_write_q;
    assign WriteRegister = wr_reg_q;
    assign WriteData     = wr_data_q;
    assign Busy          = full_a_q | full_b_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector table, hand sequences,
// and random traffic checked against a queue-based reference model and a shadow register file.
module tb_regfile_write_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        ReqValidA, ReqValidB;
    logic [4:0]  ReqRegA, ReqRegB;
    logic [31:0] ReqDataA, ReqDataB;
    logic        ReqReadyA, ReqReadyB;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic        Busy;

    regfile_write_arbiter dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .ReqValidA    (ReqValidA),
        .ReqValidB    (ReqValidB),
        .ReqRegA      (ReqRegA),
        .ReqRegB      (ReqRegB),
        .ReqDataA     (ReqDataA),
        .ReqDataB     (ReqDataB),
        .ReqReadyA    (ReqReadyA),
        .ReqReadyB    (ReqReadyB),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .RegWrite     (RegWrite),
        .Busy         (Busy)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Register file as seen through the DUT's write port.
    logic [31:0] shadow [32];
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 32; i++) shadow[i] <= 32'd0;
        end else if (RegWrite) begin
            shadow[WriteRegister] <= WriteData;
        end
    end

    // Reference model: pending writes per requester, the resulting register file contents,
    // and the expected write-port values.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } entry_t;

    entry_t      qa[$];
    entry_t      qb[$];
    bit          last_contended_a;
    logic [31:0] rf_model [32];
    logic        exp_rw;
    logic [4:0]  exp_wreg;
    logic [31:0] exp_wdata;

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_contended_a = 1'b0;
        exp_rw    = 1'b0;
        exp_wreg  = 5'd0;
        exp_wdata = 32'd0;
        for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    endtask

    // 0: nobody pending, 1: A served, 2: B served.
    function automatic int pick();
        if (qa.size() > 0 && qb.size() > 0) begin
`ifdef REGARB_ROUND_ROBIN_EN
            return last_contended_a ? 2 : 1;
`else
            return 1;
`endif
        end
        if (qa.size() > 0) return 1;
        if (qb.size() > 0) return 2;
        return 0;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic va, input logic [4:0] ra, input logic [31:0] da,
                         input logic vb, input logic [4:0] rb, input logic [31:0] db);
        int     p;
        bit     rdy_a, rdy_b;
        bit     contended;
        entry_t e;
        ReqValidA = va; ReqRegA = ra; ReqDataA = da;
        ReqValidB = vb; ReqRegB = rb; ReqDataB = db;
        #1;
        p         = pick();
        contended = (qa.size() > 0) && (qb.size() > 0);
        rdy_a     = (qa.size() == 0) || (p == 1);
        rdy_b     = (qb.size() == 0) || (p == 2);
        chk("ready_a", ReqReadyA, rdy_a);
        chk("ready_b", ReqReadyB, rdy_b);
        chk("busy", Busy, (qa.size() + qb.size()) > 0);
        exp_rw = 1'b0;
        if (p == 1) e = qa.pop_front();
        if (p == 2) e = qb.pop_front();
        if (p != 0) begin
            exp_rw    = 1'b1;
            exp_wreg  = e.r;
            exp_wdata = e.d;
            rf_model[e.r] = e.d;
            if (contended) last_contended_a = (p == 1);
        end
        if (va && rdy_a && ra != 5'd0) qa.push_back('{r: ra, d: da});
        if (vb && rdy_b && rb != 5'd0) qb.push_back('{r: rb, d: db});
        @(posedge Clk);
        @(negedge Clk);
        chk("regwrite", RegWrite, exp_rw);
        chk("write_register", WriteRegister, exp_wreg);
        chk("write_data", WriteData, exp_wdata);
        $display("cycle va=%0b ra=%0d vb=%0b rb=%0d -> rw=%0b wreg=%0d wdata=0x%08h",
                 va, ra, vb, rb, RegWrite, WriteRegister, WriteData);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n   = 1'b0;
        ReqValidA = 1'b0; ReqRegA = 5'd0; ReqDataA = 32'd0;
        ReqValidB = 1'b0; ReqRegB = 5'd0; ReqDataB = 32'd0;
        #1;
        chk("rst_ready_a", ReqReadyA, 1'b0);
        chk("rst_ready_b", ReqReadyB, 1'b0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_regwrite", RegWrite, 1'b0);
        chk("rst_wreg", WriteRegister, 5'd0);
        chk("rst_wdata", WriteData, 32'd0);
        chk("rst_busy", Busy, 1'b0);
        Reset_n = 1'b1;
        #1;
        chk("post_rst_ready_a", ReqReadyA, 1'b1);
        chk("post_rst_ready_b", ReqReadyB, 1'b1);
        @(negedge Clk);
    endtask

    typedef struct {
        logic        va;
        logic [4:0]  ra;
        logic [31:0] da;
        logic        vb;
        logic [4:0]  rb;
        logic [31:0] db;
        logic        e_ra;
        logic        e_rb;
        logic        e_busy;
        logic        e_rw;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl [9];

    initial begin
        Reset_n   = 1'b0;
        ReqValidA = 1'b0; ReqRegA = 5'd0; ReqDataA = 32'd0;
        ReqValidB = 1'b0; ReqRegB = 5'd0; ReqDataB = 32'd0;

        tbl[0] = '{1'b1, 5'd17, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
        tbl[1] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd17, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 5'd0,  32'd50,       1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd17, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd17, 32'hDEADBEEF};
        tbl[4] = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd5, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b0, 5'd17, 32'hDEADBEEF};
        tbl[5] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5,  32'hCAFEF00D};
        tbl[6] = '{1'b1, 5'd2,  32'h13579BDF, 1'b1, 5'd0, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5,  32'hCAFEF00D};
        tbl[7] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2,  32'h13579BDF};
        tbl[8] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2,  32'h13579BDF};

        do_reset();

        for (int i = 0; i < 9; i++) begin
            ReqValidA = tbl[i].va; ReqRegA = tbl[i].ra; ReqDataA = tbl[i].da;
            ReqValidB = tbl[i].vb; ReqRegB = tbl[i].rb; ReqDataB = tbl[i].db;
            #1;
            chk($sformatf("vec%0d_ready_a", i), ReqReadyA, tbl[i].e_ra);
            chk($sformatf("vec%0d_ready_b", i), ReqReadyB, tbl[i].e_rb);
            chk($sformatf("vec%0d_busy", i), Busy, tbl[i].e_busy);
            @(posedge Clk);
            @(negedge Clk);
            chk($sformatf("vec%0d_regwrite", i), RegWrite, tbl[i].e_rw);
            chk($sformatf("vec%0d_wreg", i), WriteRegister, tbl[i].e_wreg);
            chk($sformatf("vec%0d_wdata", i), WriteData, tbl[i].e_wdata);
            $display("vec%0d rw=%0b wreg=%0d wdata=0x%08h", i, RegWrite, WriteRegister, WriteData);
        end

        do_reset();
        model_reset();

        // Simultaneous accept: A first after reset, then B.
        cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("pair1_first_reg", WriteRegister, 5'd3);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("pair1_second_reg", WriteRegister, 5'd4);

        // Both target register 9: the later-granted value must persist.
        cycle(1'b1, 5'd9, 32'h00BADA55, 1'b1, 5'd9, 32'h12345678);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifdef REGARB_ROUND_ROBIN_EN
        chk("pair2_first_data", WriteData, 32'h12345678);
`else
        chk("pair2_first_data", WriteData, 32'h00BADA55);
`endif
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifdef REGARB_ROUND_ROBIN_EN
        chk("reg9_final", shadow[9], 32'h00BADA55);
`else
        chk("reg9_final", shadow[9], 32'h12345678);
`endif

        // A refilled every cycle while B holds an entry.
        cycle(1'b1, 5'd8, 32'hA0, 1'b1, 5'd7, 32'hB0);
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1, 5'd8, 32'hA0 + k, 1'b0, 5'd0, 32'd0);
`ifndef REGARB_ROUND_ROBIN_EN
            chk("b_stalled", ReqReadyB, 1'b0);
`endif
        end
        repeat (3) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rb = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cycle(1'($urandom_range(0, 1)), ra, $urandom,
                  1'($urandom_range(0, 1)), rb, $urandom);
        end
        repeat (4) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), shadow[i], rf_model[i]);

        // Reset mid-operation with a write on the port and B still buffered.
        cycle(1'b1, 5'd10, 32'h1010, 1'b1, 5'd11, 32'h1111);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("midrst_regwrite", RegWrite, 1'b0);
        chk("midrst_busy", Busy, 1'b0);
        chk("midrst_ready_a", ReqReadyA, 1'b0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        repeat (3) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
